// File: rtl/fwd_scoreboard_if.sv
// Operand-forwarding / scoreboard bundle between decode-issue control and fwd_scoreboard.
// The master side drives the read requests, forwarding buses, issue and writeback; the slave side returns the resolved operands.
interface fwd_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2,
    parameter int N_FWD  = 3
);
    localparam int FWD_W = DATA_W + ADDR_W + 2;

    logic [N_RD-1:0]         rd_en;
    logic [N_RD*ADDR_W-1:0]  rd_addr;
    logic [N_RD*DATA_W-1:0]  rf_data;
    logic [N_RD*DATA_W-1:0]  imm;
    logic [N_FWD*FWD_W-1:0]  fwd_info;
    logic                    issue_valid;
    logic                    issue_long;
    logic [ADDR_W-1:0]       issue_waddr;
    logic                    wb_valid;
    logic [ADDR_W-1:0]       wb_addr;
    logic [DATA_W-1:0]       wb_data;
    logic                    flush;
    logic [N_RD*DATA_W-1:0]  ope_data;
    logic [N_RD-1:0]         ope_valid;
    logic                    stall;
    logic                    pend_any;
    logic                    sb_err;

    modport master (
        output rd_en, rd_addr, rf_data, imm, fwd_info,
        output issue_valid, issue_long, issue_waddr,
        output wb_valid, wb_addr, wb_data, flush,
        input  ope_data, ope_valid, stall, pend_any, sb_err
    );

    modport slave (
        input  rd_en, rd_addr, rf_data, imm, fwd_info,
        input  issue_valid, issue_long, issue_waddr,
        input  wb_valid, wb_addr, wb_data, flush,
        output ope_data, ope_valid, stall, pend_any, sb_err
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand forwarding and hazard detection for decode/issue: per-port youngest-wins bypass,
// long-latency writeback bypass and a per-register pending-result scoreboard.

// One source-operand port: picks imm, youngest forwarding hit, writeback bypass or RF data.
module fwd_port_resolve #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_FWD  = 3,
    parameter int CNT_W  = 2
) (
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [DATA_W-1:0]             rf_data,
    input  logic [DATA_W-1:0]             imm,
    input  logic [N_FWD-1:0][DATA_W-1:0]  fwd_data,
    input  logic [N_FWD-1:0][ADDR_W-1:0]  fwd_addr,
    input  logic [N_FWD-1:0]              fwd_wen,
    input  logic [N_FWD-1:0]              fwd_fin,
    input  logic                          wb_valid,
    input  logic [ADDR_W-1:0]             wb_addr,
    input  logic [DATA_W-1:0]             wb_data,
    input  logic [CNT_W-1:0]              pend_cnt,
    output logic [DATA_W-1:0]             ope_data,
    output logic                          ope_valid
);
    logic              hit_any;
    logic [DATA_W-1:0] hit_data;
    logic              hit_fin;

    // Ascending scan: a later (younger) hit overwrites an older one.
    always_comb begin
        hit_any  = 1'b0;
        hit_data = '0;
        hit_fin  = 1'b0;
        for (int i = 0; i < N_FWD; i++) begin
            if (fwd_wen[i] && (fwd_addr[i] == rd_addr)) begin
                hit_any  = 1'b1;
                hit_data = fwd_data[i];
                hit_fin  = fwd_fin[i];
            end
        end
    end

    always_comb begin
        ope_data  = rf_data;
        ope_valid = 1'b1;
        if (!rd_en) begin
            ope_data  = imm;
            ope_valid = 1'b1;
        end else if (rd_addr == '0) begin
            ope_data  = rf_data;
            ope_valid = 1'b1;
        end else if (hit_any) begin
            ope_data  = hit_data;
            ope_valid = hit_fin;
        end else if (wb_valid && (wb_addr == rd_addr)) begin
            // Final only when this writeback retires the last outstanding result.
            ope_data  = wb_data;
            ope_valid = (pend_cnt == CNT_W'(1));
        end else begin
            ope_data  = rf_data;
            ope_valid = (pend_cnt == '0);
        end
    end
endmodule

module fwd_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2,
    parameter int N_FWD  = 3,
    parameter int CNT_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    fwd_scoreboard_if.slave  sb
);
    localparam int NREG = 1 << ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic              finish;
    } fwd_bus_t;

    fwd_bus_t [N_FWD-1:0]            fwd;
    logic [N_FWD-1:0][DATA_W-1:0]    fwd_data;
    logic [N_FWD-1:0][ADDR_W-1:0]    fwd_addr;
    logic [N_FWD-1:0]                fwd_wen;
    logic [N_FWD-1:0]                fwd_fin;

    logic [NREG-1:0][CNT_W-1:0]      pend;
    logic [NREG-1:0]                 inc, dec, full, empty;
    logic                            err_evt;

    logic [N_RD-1:0][ADDR_W-1:0]     port_addr;
    logic [N_RD-1:0][DATA_W-1:0]     port_rf, port_imm, port_data;
    logic [N_RD-1:0][CNT_W-1:0]      port_pend;
    logic [N_RD-1:0]                 port_valid;

    assign fwd       = sb.fwd_info;
    assign port_addr = sb.rd_addr;
    assign port_rf   = sb.rf_data;
    assign port_imm  = sb.imm;

    for (genvar i = 0; i < N_FWD; i++) begin : g_fwd
        assign fwd_data[i] = fwd[i].data;
        assign fwd_addr[i] = fwd[i].addr;
        assign fwd_wen[i]  = fwd[i].wen;
        assign fwd_fin[i]  = fwd[i].finish;
    end

    for (genvar j = 0; j < N_RD; j++) begin : g_port
        // pend[0] is held at zero, so r0 reads never see a pending count.
        assign port_pend[j] = pend[port_addr[j]];

        fwd_port_resolve #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .N_FWD  (N_FWD),
            .CNT_W  (CNT_W)
        ) u_port (
            .rd_en     (sb.rd_en[j]),
            .rd_addr   (port_addr[j]),
            .rf_data   (port_rf[j]),
            .imm       (port_imm[j]),
            .fwd_data  (fwd_data),
            .fwd_addr  (fwd_addr),
            .fwd_wen   (fwd_wen),
            .fwd_fin   (fwd_fin),
            .wb_valid  (sb.wb_valid),
            .wb_addr   (sb.wb_addr),
            .wb_data   (sb.wb_data),
            .pend_cnt  (port_pend[j]),
            .ope_data  (port_data[j]),
            .ope_valid (port_valid[j])
        );
    end

    assign sb.ope_data  = port_data;
    assign sb.ope_valid = port_valid;
    assign sb.stall     = ~&port_valid;
    assign sb.pend_any  = |pend;

    always_comb begin
        inc = '0;
        dec = '0;
        if (sb.issue_valid && sb.issue_long) inc[sb.issue_waddr] = 1'b1;
        if (sb.wb_valid)                     dec[sb.wb_addr]     = 1'b1;
        inc[0] = 1'b0;
        dec[0] = 1'b0;
    end

    for (genvar r = 0; r < NREG; r++) begin : g_lvl
        assign full[r]  = &pend[r];
        assign empty[r] = ~|pend[r];
    end

    // Same-register inc+dec cancels, so it can never raise an error.
    assign err_evt = |(inc & ~dec & full) | |(dec & ~inc & empty);

    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            pend <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc[r] && !dec[r] && !full[r])
                    pend[r] <= pend[r] + CNT_W'(1);
                else if (dec[r] && !inc[r] && !empty[r])
                    pend[r] <= pend[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            sb.sb_err <= 1'b0;
        else if (!sb.flush && err_evt)
            sb.sb_err <= 1'b1;
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed plus randomized bench for fwd_scoreboard against a behavioural operand/pending model.
module tb_fwd_scoreboard;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;
    localparam int N_FWD  = 3;
    localparam int CNT_W  = 2;
    localparam int FW     = DATA_W + ADDR_W + 2;
    localparam int NREG   = 1 << ADDR_W;
    localparam int PMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .N_FWD(N_FWD)) bif ();

    fwd_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .N_FWD(N_FWD), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bif)
    );

    int checks = 0;
    int errors = 0;
    int pend_m [NREG];
    bit err_m;

    task automatic expect_eq(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bif.rd_en = '0; bif.rd_addr = '0; bif.rf_data = '0; bif.imm = '0;
        bif.fwd_info = '0; bif.issue_valid = 1'b0; bif.issue_long = 1'b0;
        bif.issue_waddr = '0; bif.wb_valid = 1'b0; bif.wb_addr = '0;
        bif.wb_data = '0; bif.flush = 1'b0;
    endtask

    task automatic set_rd(int j, logic en, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] rf,
                          logic [DATA_W-1:0] im);
        bif.rd_en[j] = en;
        bif.rd_addr[j*ADDR_W +: ADDR_W] = a;
        bif.rf_data[j*DATA_W +: DATA_W] = rf;
        bif.imm[j*DATA_W +: DATA_W] = im;
    endtask

    task automatic set_bus(int i, logic [DATA_W-1:0] d, logic [ADDR_W-1:0] a, logic w, logic f);
        bif.fwd_info[i*FW +: FW] = {d, a, w, f};
    endtask

    task automatic issue(logic [ADDR_W-1:0] a);
        bif.issue_valid = 1'b1; bif.issue_long = 1'b1; bif.issue_waddr = a;
    endtask

    task automatic wb(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        bif.wb_valid = 1'b1; bif.wb_addr = a; bif.wb_data = d;
    endtask

    // Operand value a port should see, straight from the resolution rules.
    function automatic void model_port(int j, output logic [DATA_W-1:0] d, output logic v);
        int a;
        bit found;
        logic [FW-1:0] b;
        a = int'(bif.rd_addr[j*ADDR_W +: ADDR_W]);
        found = 0;
        d = bif.rf_data[j*DATA_W +: DATA_W];
        v = 1'b1;
        if (!bif.rd_en[j]) begin
            d = bif.imm[j*DATA_W +: DATA_W];
            return;
        end
        if (a == 0) return;
        for (int i = N_FWD - 1; i >= 0 && !found; i--) begin
            b = bif.fwd_info[i*FW +: FW];
            if (b[1] && int'(b[2 +: ADDR_W]) == a) begin
                found = 1;
                d = b[ADDR_W+2 +: DATA_W];
                v = b[0];
            end
        end
        if (found) return;
        if (bif.wb_valid && int'(bif.wb_addr) == a) begin
            d = bif.wb_data;
            v = (pend_m[a] == 1);
        end else begin
            v = (pend_m[a] == 0);
        end
    endfunction

    function automatic void model_update();
        int ia, wa;
        ia = (bif.issue_valid && bif.issue_long) ? int'(bif.issue_waddr) : 0;
        wa = bif.wb_valid ? int'(bif.wb_addr) : 0;
        if (rst) begin
            foreach (pend_m[r]) pend_m[r] = 0;
            err_m = 0;
        end else if (bif.flush) begin
            foreach (pend_m[r]) pend_m[r] = 0;
        end else if (!(ia != 0 && ia == wa)) begin
            if (ia != 0) begin
                if (pend_m[ia] == PMAX) err_m = 1; else pend_m[ia]++;
            end
            if (wa != 0) begin
                if (pend_m[wa] == 0) err_m = 1; else pend_m[wa]--;
            end
        end
    endfunction

    // Compare every output with the model mid-cycle, then advance model and clock together.
    task automatic tick(string tag);
        logic [DATA_W-1:0] d;
        logic v;
        logic [N_RD-1:0] vexp;
        bit any;
        #3;
        for (int j = 0; j < N_RD; j++) begin
            model_port(j, d, v);
            vexp[j] = v;
            expect_eq($sformatf("%s.data%0d", tag, j), bif.ope_data[j*DATA_W +: DATA_W], d);
            expect_eq($sformatf("%s.valid%0d", tag, j), bif.ope_valid[j], v);
        end
        any = 0;
        foreach (pend_m[r]) if (pend_m[r] != 0) any = 1;
        expect_eq({tag, ".stall"}, bif.stall, ~&vexp);
        expect_eq({tag, ".pend_any"}, bif.pend_any, any);
        expect_eq({tag, ".sb_err"}, bif.sb_err, err_m);
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        foreach (pend_m[r]) pend_m[r] = 0;
        err_m = 0;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick("reset");
        rst = 1'b0;
        #1;
        expect_eq("rst_pend_any", bif.pend_any, 0);
        expect_eq("rst_sb_err", bif.sb_err, 0);

        // Youngest bus wins over an older bus on the same register.
        set_rd(0, 1, 5, 32'h1111, 0);
        set_rd(1, 0, 0, 0, 32'h22);
        set_bus(2, 32'hAAAA, 5, 1, 1);
        set_bus(0, 32'hBBBB, 5, 1, 1);
        #1;
        expect_eq("young_data", bif.ope_data[0 +: DATA_W], 32'hAAAA);
        expect_eq("young_valid", bif.ope_valid[0], 1);
        expect_eq("young_stall", bif.stall, 0);
        tick("young");

        // Unfinished youngest hit stalls even with a finished older hit; port0 takes imm.
        clear_inputs();
        set_bus(2, 32'h5555, 7, 1, 0);
        set_bus(0, 32'h6666, 7, 1, 1);
        set_rd(1, 1, 7, 32'h77, 0);
        set_rd(0, 0, 0, 0, 32'h10);
        #1;
        expect_eq("unfin_valid1", bif.ope_valid[1], 0);
        expect_eq("unfin_stall", bif.stall, 1);
        expect_eq("imm_data0", bif.ope_data[0 +: DATA_W], 32'h10);
        expect_eq("imm_valid0", bif.ope_valid[0], 1);
        tick("unfin");

        // Long-latency r9: pending until its writeback.
        clear_inputs();
        issue(9);
        tick("iss9");
        clear_inputs();
        for (int k = 0; k < 10; k++) begin
            set_rd(0, 1, 9, 32'h99, 0);
            #1;
            expect_eq("r9_pending", bif.ope_valid[0], 0);
            tick("r9_wait");
        end
        wb(9, 32'h1234);
        #1;
        expect_eq("r9_wb_data", bif.ope_data[0 +: DATA_W], 32'h1234);
        expect_eq("r9_wb_valid", bif.ope_valid[0], 1);
        tick("r9_wb");
        clear_inputs();
        set_rd(0, 1, 9, 32'h99, 0);
        #1;
        expect_eq("r9_rf_data", bif.ope_data[0 +: DATA_W], 32'h99);
        expect_eq("r9_rf_valid", bif.ope_valid[0], 1);
        expect_eq("r9_pend_any", bif.pend_any, 0);
        tick("r9_rf");

        // Two outstanding results on r3.
        clear_inputs();
        issue(3); tick("iss3a");
        issue(3); tick("iss3b");
        clear_inputs();
        set_rd(0, 1, 3, 32'h33, 0);
        wb(3, 32'h3003);
        #1;
        expect_eq("r3_first_wb", bif.ope_valid[0], 0);
        tick("r3_wb1");
        #0;
        expect_eq("r3_second_wb", bif.ope_valid[0], 1);
        tick("r3_wb2");
        clear_inputs();
        issue(3); tick("iss3c");
        issue(3); wb(3, 32'h3333); tick("r3_incdec");
        clear_inputs();
        set_rd(0, 1, 3, 32'h33, 0);
        #1;
        expect_eq("r3_hold_valid", bif.ope_valid[0], 0);
        expect_eq("r3_hold_pend", bif.pend_any, 1);
        tick("r3_hold");
        clear_inputs();
        wb(3, 0); tick("r3_drain");

        // Register 0 ignores buses and is never tracked.
        clear_inputs();
        set_bus(1, 32'hFFFF, 0, 1, 1);
        set_rd(0, 1, 0, 0, 32'h5);
        wb(0, 32'hDEAD);
        #1;
        expect_eq("r0_data", bif.ope_data[0 +: DATA_W], 0);
        expect_eq("r0_valid", bif.ope_valid[0], 1);
        tick("r0");
        clear_inputs();
        #1;
        expect_eq("r0_no_err", bif.sb_err, 0);

        // Underflow error is sticky through flush; flush clears pending; rst clears error.
        wb(4, 0); tick("uflow");
        clear_inputs();
        #1;
        expect_eq("uflow_err", bif.sb_err, 1);
        bif.flush = 1'b1; tick("flush_err");
        clear_inputs();
        #1;
        expect_eq("err_after_flush", bif.sb_err, 1);
        issue(6); tick("iss6");
        clear_inputs();
        #1;
        expect_eq("pend6", bif.pend_any, 1);
        bif.flush = 1'b1; issue(6); tick("flush6");
        clear_inputs();
        #1;
        expect_eq("flush_pend_any", bif.pend_any, 0);
        rst = 1'b1; tick("rst_mid");
        rst = 1'b0;
        #1;
        expect_eq("rst_clears_err", bif.sb_err, 0);

        // Randomized traffic over a small register window to force hits and collisions.
        for (int n = 0; n < 600; n++) begin
            clear_inputs();
            for (int j = 0; j < N_RD; j++)
                set_rd(j, 1'($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)),
                       $urandom, $urandom);
            for (int i = 0; i < N_FWD; i++)
                set_bus(i, $urandom, ADDR_W'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            bif.issue_valid = 1'($urandom_range(0, 1));
            bif.issue_long  = 1'($urandom_range(0, 1));
            bif.issue_waddr = ADDR_W'($urandom_range(0, 7));
            bif.wb_valid    = 1'($urandom_range(0, 2) == 0);
            bif.wb_addr     = ADDR_W'($urandom_range(0, 7));
            bif.wb_data     = $urandom;
            bif.flush       = 1'($urandom_range(0, 39) == 0);
            rst             = 1'($urandom_range(0, 149) == 0);
            tick("rnd");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
